operand_stage: RTL and testbench

//  Decode/execute boundary register and forwarding consumer. Applies the per-operand forward selects
//  and the load-use stall from the forwarding unit, muxes rs1/rs2 from EX result, MEM result or regfile,

---
 rtl/operand_stage_pkg.sv | 21 ++
 rtl/operand_stage_if.sv | 40 ++++
 rtl/operand_stage_mux.sv | 26 ++
 rtl/operand_stage.sv | 118 +++++++++++
 tb/tb_operand_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/operand_stage_pkg.sv
// Shared types for the decode/execute operand stage: forward selects, register-zero index
// and output-register states.
package operand_stage_pkg;

  typedef struct packed {
    logic ex;
    logic mem;
  } fwd_type_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } os_state_t;

  function automatic logic fwd_conflict(input fwd_type_t f);
    return f.ex & f.mem;
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Decode-side, forwarding-side and execute-side signals of the operand stage.
// The slave view is the stage itself; master is the surrounding pipeline.
interface operand_stage_if #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64
) ();
  import operand_stage_pkg::*;

  logic                 de_valid;
  logic                 de_ready;
  logic [4:0]           de_rs1;
  logic [4:0]           de_rs2;
  logic [XLEN-1:0]      rf_rs1_data;
  logic [XLEN-1:0]      rf_rs2_data;
  logic [PAYLOAD_W-1:0] de_payload;
  logic                 fwd_stall;
  fwd_type_t            fwd_rs1;
  fwd_type_t            fwd_rs2;
  logic [XLEN-1:0]      ex_result;
  logic [XLEN-1:0]      mem_result;
  logic                 flush;
  logic                 op_valid;
  logic                 ex_ready;
  logic [XLEN-1:0]      op_a;
  logic [XLEN-1:0]      op_b;
  logic [PAYLOAD_W-1:0] op_payload;

  modport master (
    output de_valid, de_rs1, de_rs2, rf_rs1_data, rf_rs2_data, de_payload,
    output fwd_stall, fwd_rs1, fwd_rs2, ex_result, mem_result, flush, ex_ready,
    input  de_ready, op_valid, op_a, op_b, op_payload
  );

  modport slave (
    input  de_valid, de_rs1, de_rs2, rf_rs1_data, rf_rs2_data, de_payload,
    input  fwd_stall, fwd_rs1, fwd_rs2, ex_result, mem_result, flush, ex_ready,
    output de_ready, op_valid, op_a, op_b, op_payload
  );

endinterface

// File: rtl/operand_stage_mux.sv
// Single-source operand select: EX forward, then MEM forward, then regfile; x0 always reads zero.
module operand_mux
  import operand_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs,
  input  fwd_type_t       fwd,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] ex_data,
  input  logic [XLEN-1:0] mem_data,
  output logic [XLEN-1:0] operand
);

  always_comb begin
    operand = rf_data;
    if (rs == REG_ZERO) begin
      operand = '0;
    end else if (fwd.ex) begin
      operand = ex_data;
    end else if (fwd.mem) begin
      operand = mem_data;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// Decode/execute boundary register: resolves forwarded operands, registers them with the control
// payload under valid/ready, inserts bubbles on load-use stall or flush, counts stall cycles.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64,
  parameter int STALL_CW  = 16
) (
  input  logic                clk,
  input  logic                reset,
  operand_stage_if.slave      bus,
  input  logic                perf_clr,
  output logic [STALL_CW-1:0] stall_cnt
);

  os_state_t            state_p1;
  os_state_t            state_nxt;
  logic                 vld_p1;
  logic                 space;
  logic                 accept;
  logic                 load;
  logic                 stall_evt;
  logic [XLEN-1:0]      a_p0;
  logic [XLEN-1:0]      b_p0;
  logic [XLEN-1:0]      a_p1;
  logic [XLEN-1:0]      b_p1;
  logic [PAYLOAD_W-1:0] pay_p1;
  logic [STALL_CW-1:0]  cnt_q;

  function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v);
    return (&v) ? v : v + {{(STALL_CW-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: operand resolution against the instruction currently presented by decode
  operand_mux #(.XLEN(XLEN)) u_mux_a (
    .rs       (bus.de_rs1),
    .fwd      (bus.fwd_rs1),
    .rf_data  (bus.rf_rs1_data),
    .ex_data  (bus.ex_result),
    .mem_data (bus.mem_result),
    .operand  (a_p0)
  );

  operand_mux #(.XLEN(XLEN)) u_mux_b (
    .rs       (bus.de_rs2),
    .fwd      (bus.fwd_rs2),
    .rf_data  (bus.rf_rs2_data),
    .ex_data  (bus.ex_result),
    .mem_data (bus.mem_result),
    .operand  (b_p0)
  );

  assign vld_p1       = (state_p1 == FULL);
  assign space        = ~vld_p1 | bus.ex_ready;
  assign bus.de_ready = space & ~bus.fwd_stall & ~bus.flush;
  assign accept       = bus.de_valid & bus.de_ready;
  // Stall cycles only count while the output slot could have taken the instruction
  assign stall_evt    = bus.de_valid & bus.fwd_stall & ~bus.flush & space;

  always_comb begin
    state_nxt = state_p1;
    load      = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else if (accept) begin
      state_nxt = FULL;
      load      = 1'b1;
    end else if (bus.ex_ready && vld_p1) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Stage p1: registered operands and payload toward execute
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p1   <= '0;
      b_p1   <= '0;
      pay_p1 <= '0;
    end else if (load) begin
      a_p1   <= a_p0;
      b_p1   <= b_p0;
      pay_p1 <= bus.de_payload;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (perf_clr) begin
      cnt_q <= '0;
    end else if (stall_evt) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign bus.op_valid   = vld_p1;
  assign bus.op_a       = a_p1;
  assign bus.op_b       = b_p1;
  assign bus.op_payload = pay_p1;
  assign stall_cnt      = cnt_q;

  a_fwd1_onehot: assert property (@(posedge clk) disable iff (reset)
    !fwd_conflict(bus.fwd_rs1));
  a_fwd2_onehot: assert property (@(posedge clk) disable iff (reset)
    !fwd_conflict(bus.fwd_rs2));
  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (vld_p1 && !bus.ex_ready) |=> ($stable(a_p1) && $stable(b_p1) && $stable(pay_p1)));

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: expected operands queued at issue, compared by a monitor
// whenever execute consumes op_*.
module tb_operand_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       perf_clr;
  logic [3:0] stall_cnt;
  int         n_chk;
  int         n_pass;
  exp_t       exp_q[$];

  operand_stage_if #(.XLEN(32), .PAYLOAD_W(64)) bif ();

  operand_stage #(.XLEN(32), .PAYLOAD_W(64), .STALL_CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .perf_clr  (perf_clr),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] f1, input logic [1:0] f2,
                       input logic [31:0] rf1, input logic [31:0] rf2,
                       input logic [31:0] exr, input logic [31:0] memr,
                       input logic [63:0] pay);
    bif.de_rs1      = rs1;
    bif.de_rs2      = rs2;
    bif.fwd_rs1     = f1;
    bif.fwd_rs2     = f2;
    bif.rf_rs1_data = rf1;
    bif.rf_rs2_data = rf2;
    bif.ex_result   = exr;
    bif.mem_result  = memr;
    bif.de_payload  = pay;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    exp_t e;
    e.a = a;
    e.b = b;
    e.p = p;
    exp_q.push_back(e);
  endtask

  // Monitor: a consumed output must match the oldest queued expectation; flushed holds are dropped
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bif.op_valid) begin
      if (bif.ex_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_op_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_op_a", {32'd0, bif.op_a}, {32'd0, e.a});
          check("sb_op_b", {32'd0, bif.op_b}, {32'd0, e.b});
          check("sb_op_payload", bif.op_payload, e.p);
        end
      end else if (bif.flush && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    perf_clr = 1'b0;
    bif.de_valid = 1'b0;
    bif.fwd_stall = 1'b0;
    bif.flush = 1'b0;
    bif.ex_ready = 1'b1;
    drive(5'd0, 5'd0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 64'd0);
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    check("rst_op_valid", {63'd0, bif.op_valid}, 64'd0);
    check("rst_op_a", {32'd0, bif.op_a}, 64'd0);
    check("rst_op_payload", bif.op_payload, 64'd0);
    check("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);

    // EX forward on rs1 wins over regfile
    drive(5'd5, 5'd0, 2'b10, 2'b00, 32'h1234, 32'd0, 32'hAAAA_0001, 32'd0, 64'h1);
    bif.de_valid = 1'b1;
    push(32'hAAAA_0001, 32'd0, 64'h1);
    #1 check("t1_de_ready", {63'd0, bif.de_ready}, 64'd1);
    cyc();
    check("t1_op_valid", {63'd0, bif.op_valid}, 64'd1);
    check("t1_op_a", {32'd0, bif.op_a}, 64'hAAAA_0001);

    // MEM forward on rs2, then x0 ignores an EX forward
    drive(5'd3, 5'd7, 2'b00, 2'b01, 32'h10, 32'h99, 32'hDEAD, 32'h55, 64'h2);
    push(32'h10, 32'h55, 64'h2);
    cyc();
    check("t2_op_b", {32'd0, bif.op_b}, 64'h55);
    drive(5'd0, 5'd0, 2'b10, 2'b00, 32'h11, 32'd0, 32'hFF, 32'd0, 64'h3);
    push(32'd0, 32'd0, 64'h3);
    cyc();
    check("t2_op_a_zero", {32'd0, bif.op_a}, 64'd0);
    bif.de_valid = 1'b0;
    cyc();
    check("t2_drain", {63'd0, bif.op_valid}, 64'd0);

    // Load-use stall for two cycles, then accept
    drive(5'd1, 5'd0, 2'b00, 2'b00, 32'h77, 32'd0, 32'd0, 32'd0, 64'h4);
    bif.de_valid = 1'b1;
    bif.fwd_stall = 1'b1;
    #1 check("t3_de_ready_stall", {63'd0, bif.de_ready}, 64'd0);
    cyc();
    check("t3_bubble1", {63'd0, bif.op_valid}, 64'd0);
    cyc();
    check("t3_bubble2", {63'd0, bif.op_valid}, 64'd0);
    check("t3_stall_cnt", {60'd0, stall_cnt}, 64'd2);
    bif.fwd_stall = 1'b0;
    push(32'h77, 32'd0, 64'h4);
    #1 check("t3_de_ready_go", {63'd0, bif.de_ready}, 64'd1);
    cyc();
    check("t3_op_valid", {63'd0, bif.op_valid}, 64'd1);

    // Backpressure: outputs hold while inputs move; stall during backpressure not counted
    bif.ex_ready = 1'b0;
    bif.fwd_stall = 1'b1;
    drive(5'd2, 5'd0, 2'b00, 2'b00, 32'h222, 32'd0, 32'd0, 32'd0, 64'h5);
    #1 check("t4_de_ready_bp", {63'd0, bif.de_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_hold_valid", {63'd0, bif.op_valid}, 64'd1);
      check("t4_hold_a", {32'd0, bif.op_a}, 64'h77);
      check("t4_hold_payload", bif.op_payload, 64'h4);
      bif.rf_rs1_data = 32'h300 + i;
    end
    check("t4_bp_not_counted", {60'd0, stall_cnt}, 64'd2);
    bif.ex_ready = 1'b1;
    bif.fwd_stall = 1'b0;
    bif.rf_rs1_data = 32'h333;
    push(32'h333, 32'd0, 64'h5);
    cyc();
    check("t4_b2b_valid", {63'd0, bif.op_valid}, 64'd1);
    check("t4_b2b_a", {32'd0, bif.op_a}, 64'h333);
    bif.de_valid = 1'b0;
    bif.fwd_stall = 1'b1;
    cyc();
    check("t4_idle_valid", {63'd0, bif.op_valid}, 64'd0);
    check("t4_idle_stall_ignored", {60'd0, stall_cnt}, 64'd2);
    bif.fwd_stall = 1'b0;

    // Flush kills the held instruction and blocks the incoming one
    drive(5'd4, 5'd0, 2'b00, 2'b00, 32'h44, 32'd0, 32'd0, 32'd0, 64'h6);
    bif.de_valid = 1'b1;
    push(32'h44, 32'd0, 64'h6);
    cyc();
    bif.ex_ready = 1'b0;
    bif.flush = 1'b1;
    drive(5'd8, 5'd0, 2'b00, 2'b00, 32'h88, 32'd0, 32'd0, 32'd0, 64'h7);
    #1 check("t5_de_ready_flush", {63'd0, bif.de_ready}, 64'd0);
    cyc();
    check("t5_flush_valid", {63'd0, bif.op_valid}, 64'd0);
    check("t5_flush_hold_a", {32'd0, bif.op_a}, 64'h44);
    bif.flush = 1'b0;
    push(32'h88, 32'd0, 64'h7);
    cyc();
    check("t5_refill_valid", {63'd0, bif.op_valid}, 64'd1);
    // Async reset mid-transfer
    bif.de_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", {63'd0, bif.op_valid}, 64'd0);
    check("t5_rst_a", {32'd0, bif.op_a}, 64'd0);
    check("t5_rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    exp_q.delete();
    cyc();
    reset = 1'b0;
    bif.ex_ready = 1'b1;

    // Saturation of the 4-bit counter, clear priority, then resume
    bif.de_valid = 1'b1;
    bif.fwd_stall = 1'b1;
    repeat (20) cyc();
    check("t6_saturate", {60'd0, stall_cnt}, 64'd15);
    perf_clr = 1'b1;
    cyc();
    check("t6_clear", {60'd0, stall_cnt}, 64'd0);
    perf_clr = 1'b0;
    cyc();
    check("t6_resume", {60'd0, stall_cnt}, 64'd1);
    bif.de_valid = 1'b0;
    bif.fwd_stall = 1'b0;
    repeat (3) cyc();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
